// File: rtl/conv1_calc.sv
// conv1_calc: 3x3 convolution with loadable weights and bias and a 3-stage pipeline.
// The output is a saturated fixed-point result with frame-end signalling.
module conv1_calc #(
   parameter int WIDTH       = 28,
   parameter int HEIGHT      = 36,
   parameter int DATA_BITS   = 32,
   parameter int WEIGHT_BITS = 8,
   parameter int FRAC_BITS   = 7
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          w_load,
   input  logic signed [WEIGHT_BITS-1:0] w_data,
   input  logic                          valid_in,
   input  logic signed [DATA_BITS-1:0]   data_in [0:8],
   output logic signed [DATA_BITS-1:0]   data_out,
   output logic                          valid_out,
   output logic                          ready,
   output logic                          frame_done
);
   localparam int P  = DATA_BITS + WEIGHT_BITS;
   localparam int S  = P + 2;
   localparam int T  = P + 4;
   localparam int N  = (WIDTH - 2) * (HEIGHT - 2);
   localparam int CW = $clog2(N + 1);
   typedef enum logic {LOAD, RUN} state_t;
   state_t                        r_state;
   logic [3:0]                    r_idx;
   logic signed [WEIGHT_BITS-1:0] r_coef [0:9];
   logic signed [P-1:0]           r_prod [0:8];
   logic signed [S-1:0]           r_row  [0:2];
   logic [2:0]                    r_v;
   logic [CW-1:0]                 r_cnt;
   logic [DATA_BITS-1:0]          r_out;
   logic                          r_ready;
   logic                          r_fd;
   logic signed [T-1:0]           w_tot;
   logic signed [T-1:0]           w_sh;
   logic                          w_ovf;
   logic [DATA_BITS-1:0]          w_sat;
   always_comb begin
      w_tot = T'(r_row[0]) + T'(r_row[1]) + T'(r_row[2]) + (T'(r_coef[9]) <<< FRAC_BITS);
      w_sh  = w_tot >>> FRAC_BITS;
      // in range only when every bit above the result sign bit copies it
      w_ovf = !((&w_sh[T-1:DATA_BITS-1]) || !(|w_sh[T-1:DATA_BITS-1]));
      w_sat = w_ovf ? {w_sh[T-1], {(DATA_BITS-1){~w_sh[T-1]}}} : w_sh[DATA_BITS-1:0];
   end
   always_ff @(posedge clk) begin
      for (int i = 0; i < 9; i++)
         r_prod[i] <= P'(data_in[i]) * P'(r_coef[i]);
      for (int r = 0; r < 3; r++)
         r_row[r] <= S'(r_prod[3*r]) + S'(r_prod[3*r+1]) + S'(r_prod[3*r+2]);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= LOAD;
         r_idx   <= '0;
         for (int i = 0; i < 10; i++)
            r_coef[i] <= '0;
         r_v     <= '0;
         r_cnt   <= '0;
         r_out   <= '0;
         r_ready <= 1'b0;
         r_fd    <= 1'b0;
      end else begin
         if (r_state == LOAD && w_load) begin
            r_coef[r_idx] <= w_data;
            r_idx         <= r_idx + 4'd1;
            if (r_idx == 4'd9) begin
               r_state <= RUN;
               r_ready <= 1'b1;
            end
         end
         r_v   <= {r_v[1:0], valid_in && r_state == RUN};
         r_out <= w_sat;
         r_fd  <= r_v[1] && r_cnt == CW'(N - 1);
         if (r_v[1])
            r_cnt <= (r_cnt == CW'(N - 1)) ? '0 : r_cnt + 1'b1;
      end
   end
   assign data_out   = r_out;
   assign valid_out  = r_v[2];
   assign ready      = r_ready;
   assign frame_done = r_fd;
endmodule

// File: tb/tb_conv1_calc.sv
// tb_conv1_calc: directed checks of conv1_calc; instance a uses 9-bit weights with 7 fraction bits,
// instance b uses 8-bit weights with no fraction bits, both on a 5x4 frame (6 outputs per frame).
module tb_conv1_calc;
   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                w_load = 1'b0;
   logic                valid_in = 1'b0;
   logic signed [8:0]   w_data = '0;
   logic signed [31:0]  taps [0:8];
   logic signed [31:0]  a_out, b_out;
   logic                a_v, a_rdy, a_fd, b_v, b_rdy, b_fd;
   logic signed [8:0]   k_id  [0:9];
   logic signed [8:0]   k_neg [0:9];
   logic signed [8:0]   k_half[0:9];
   logic signed [8:0]   k_sum [0:9];
   logic signed [8:0]   k_sat [0:9];
   int                  n_run = 0;
   int                  n_fail = 0;
   always #5 clk = ~clk;
   conv1_calc #(.WIDTH(5), .HEIGHT(4), .DATA_BITS(32), .WEIGHT_BITS(9), .FRAC_BITS(7)) u_a (
      .clk(clk), .rst(rst), .w_load(w_load), .w_data(w_data), .valid_in(valid_in),
      .data_in(taps), .data_out(a_out), .valid_out(a_v), .ready(a_rdy), .frame_done(a_fd));
   conv1_calc #(.WIDTH(5), .HEIGHT(4), .DATA_BITS(32), .WEIGHT_BITS(8), .FRAC_BITS(0)) u_b (
      .clk(clk), .rst(rst), .w_load(w_load), .w_data(w_data[7:0]), .valid_in(valid_in),
      .data_in(taps), .data_out(b_out), .valid_out(b_v), .ready(b_rdy), .frame_done(b_fd));
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic do_rst;
      rst = 1'b1;
      valid_in = 1'b0;
      w_load = 1'b0;
      tick();
      rst = 1'b0;
   endtask
   task automatic load(input logic signed [8:0] c [0:9]);
      for (int i = 0; i < 10; i++) begin
         w_load = 1'b1;
         w_data = c[i];
         tick();
      end
      w_load = 1'b0;
   endtask
   task automatic set_all(input logic signed [31:0] v);
      for (int i = 0; i < 9; i++) taps[i] = v;
   endtask
   task automatic fire;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      tick();
      tick();
   endtask
   function automatic bit sched(input int c);
      return (c >= 0 && c < 6) || (c >= 7 && c < 13);
   endfunction
   initial begin
      k_id   = '{0, 0, 0, 0, 128, 0, 0, 0, 0, 0};
      k_neg  = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, 0};
      k_half = '{64, -128, -128, -128, -128, -128, -128, -128, -128, 0};
      k_sum  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 2};
      k_sat  = '{127, 127, 127, 127, 127, 127, 127, 127, 127, 0};
      set_all(32'sd7);
      tick();
      rst = 1'b0;
      chk("rst_valid_out", 32'(a_v), 32'd0);
      chk("rst_data_out", a_out, 32'd0);
      chk("rst_ready", 32'(a_rdy), 32'd0);
      chk("rst_frame_done", 32'(a_fd), 32'd0);
      chk("rst_ready_b", 32'(b_rdy), 32'd0);
      valid_in = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (c == 3) valid_in = 1'b0;
         tick();
         chk("load_valid_ignored", 32'(a_v), 32'd0);
      end
      for (int i = 0; i < 9; i++) begin
         w_load = 1'b1;
         w_data = k_id[i];
         tick();
      end
      w_load = 1'b0;
      chk("ready_after_9", 32'(a_rdy), 32'd0);
      w_load = 1'b1;
      w_data = k_id[9];
      tick();
      w_load = 1'b0;
      chk("ready_after_10", 32'(a_rdy), 32'd1);
      for (int i = 0; i < 9; i++) taps[i] = 32'(i * 100 + 3);
      taps[4] = 32'sd1000;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      tick();
      chk("ident_not_early", 32'(a_v), 32'd0);
      tick();
      chk("ident_valid", 32'(a_v), 32'd1);
      chk("ident_value", a_out, 32'd1000);
      tick();
      chk("ident_single_pulse", 32'(a_v), 32'd0);
      w_load = 1'b1;
      w_data = 9'sd5;
      repeat (3) tick();
      w_load = 1'b0;
      chk("run_ready_held", 32'(a_rdy), 32'd1);
      fire();
      chk("run_wload_ignored", a_out, 32'd1000);
      do_rst();
      load(k_neg);
      set_all(-32'sd5);
      fire();
      chk("neg_taps", a_out, 32'd45);
      set_all(32'sd5);
      fire();
      chk("pos_taps_neg_w", a_out, -32'sd45);
      do_rst();
      load(k_half);
      set_all(32'sd0);
      taps[0] = 32'sd1;
      fire();
      chk("floor_half", a_out, 32'd0);
      taps[0] = -32'sd1;
      fire();
      chk("floor_neg_half", a_out, -32'sd1);
      do_rst();
      load(k_sum);
      for (int i = 0; i < 9; i++) taps[i] = 32'(i + 1);
      fire();
      chk("sum_valid", 32'(b_v), 32'd1);
      chk("sum_bias", b_out, 32'd47);
      do_rst();
      load(k_sat);
      set_all(32'sh7FFFFFFF);
      fire();
      chk("sat_pos", b_out, 32'h7FFFFFFF);
      set_all(32'sh80000000);
      fire();
      chk("sat_neg", b_out, 32'h80000000);
      set_all(32'sd1);
      fire();
      chk("sat_none", b_out, 32'd1143);
      do_rst();
      load(k_id);
      set_all(32'sd0);
      for (int k = 0; k < 17; k++) begin
         valid_in = sched(k);
         taps[4] = 32'(k);
         tick();
         chk("frame_valid", 32'(a_v), 32'(k >= 2 && sched(k - 2)));
         chk("frame_done", 32'(a_fd), 32'(k >= 2 && sched(k - 2) && (k - 2 == 5 || k - 2 == 12)));
         if (k >= 2 && sched(k - 2)) chk("frame_data", a_out, 32'(k - 2));
      end
      valid_in = 1'b1;
      tick();
      tick();
      chk("burst_pre_rst", 32'(a_v), 32'd0);
      valid_in = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_valid", 32'(a_v), 32'd0);
      chk("midrst_ready", 32'(a_rdy), 32'd0);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("midrst_flush", 32'(a_v), 32'd0);
      end
      for (int i = 0; i < 9; i++) begin
         w_load = 1'b1;
         w_data = k_id[i];
         tick();
      end
      w_load = 1'b0;
      chk("reload_ready_9", 32'(a_rdy), 32'd0);
      w_load = 1'b1;
      w_data = k_id[9];
      tick();
      w_load = 1'b0;
      chk("reload_ready_10", 32'(a_rdy), 32'd1);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
